// File: rtl/sreg_tx_param.sv
// ---------------------------------------------------------------------------
// sreg_tx_param
//
// Parallel-in / serial-out transmitter. A SIZE-bit word is taken on a
// valid/ready handshake. It is then shifted out MSB first, one bit per
// enabled clock. Framing is provided by serial-valid (sv) and last-bit (last).
// A one-cycle done pulse follows the final bit. Sending bit SIZE-1 first
// means the receiving shift register holds the word in its original bit
// positions after SIZE shifts.
//
// Optional feature macro: SREG_TX_PARAM_BACK2BACK_EN
//   defined   : a new word may be accepted on the edge that retires the last
//               bit of the current word, so sv stays continuously high.
//   undefined : a new word is accepted only from IDLE, which leaves at least
//               one sv-low cycle between words.
//
// Parameters
//   SIZE   word width in bits (>= 2)
//   CNT_W  bit-counter width, derived as $clog2(SIZE)
//
// Ports
//   sreg_tx_param_cport_clk    in   clock, rising edge
//   sreg_tx_param_cport_rst    in   asynchronous reset, active low
//   sreg_tx_param_cport_en     in   clock enable; all state holds when low
//   sreg_tx_param_iport_valid  in   source presents a word
//   sreg_tx_param_ipport_pi    in   parallel word [SIZE-1:0]
//   sreg_tx_param_oport_ready  out  word accepted this cycle if valid
//   sreg_tx_param_oport_so     out  serial data (MSB of the shift register)
//   sreg_tx_param_oport_sv     out  serial valid
//   sreg_tx_param_oport_last   out  final bit of the word is on so
//   sreg_tx_param_oport_done   out  one-cycle pulse after the final bit
// ---------------------------------------------------------------------------
module sreg_tx_param #(
  parameter  int SIZE  = 512,
  localparam int CNT_W = $clog2(SIZE)
) (
  input  logic            sreg_tx_param_cport_clk,
  input  logic            sreg_tx_param_cport_rst,
  input  logic            sreg_tx_param_cport_en,
  input  logic            sreg_tx_param_iport_valid,
  input  logic [SIZE-1:0] sreg_tx_param_ipport_pi,
  output logic            sreg_tx_param_oport_ready,
  output logic            sreg_tx_param_oport_so,
  output logic            sreg_tx_param_oport_sv,
  output logic            sreg_tx_param_oport_last,
  output logic            sreg_tx_param_oport_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

  state_t            state_reg, state_next;
  logic [SIZE-1:0]   shreg_reg, shreg_next;
  logic [CNT_W-1:0]  cnt_reg,   cnt_next;
  logic              done_reg,  done_next;

  logic              at_last;
  logic              ready;
  logic              accept;

  // The final bit of the current word is on so this cycle.
  assign at_last = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);

`ifdef SREG_TX_PARAM_BACK2BACK_EN
  // Also ready on the last bit, so the next word loads on the same edge
  // that retires the current one.
  assign ready = sreg_tx_param_cport_en & ((state_reg == IDLE) | at_last);
`else
  assign ready = sreg_tx_param_cport_en & (state_reg == IDLE);
`endif

  assign accept = sreg_tx_param_iport_valid & ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge sreg_tx_param_cport_clk or negedge sreg_tx_param_cport_rst) begin
    if (!sreg_tx_param_cport_rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Everything holds while en is low, including done.
  // As a result, a done pulse that meets en=0 stretches until the next
  // enabled edge.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;

    if (sreg_tx_param_cport_en) begin
      done_next = 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            shreg_next = sreg_tx_param_ipport_pi;
            cnt_next   = '0;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_reg == CNT_LAST) begin
            done_next = 1'b1;
            if (accept) begin
              // Only reachable when back-to-back loading is enabled.
              shreg_next = sreg_tx_param_ipport_pi;
              cnt_next   = '0;
            end else begin
              // Clearing shreg keeps so low in IDLE.
              shreg_next = '0;
              state_next = IDLE;
            end
          end else begin
            shreg_next = {shreg_reg[SIZE-2:0], 1'b0};
            cnt_next   = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign sreg_tx_param_oport_ready = ready;
  assign sreg_tx_param_oport_so    = (state_reg == SHIFT) & shreg_reg[SIZE-1];
  assign sreg_tx_param_oport_sv    = (state_reg == SHIFT);
  assign sreg_tx_param_oport_last  = at_last;
  assign sreg_tx_param_oport_done  = done_reg;

endmodule

// File: tb/tb_sreg_tx_param.sv
// ---------------------------------------------------------------------------
// tb_sreg_tx_param
//
// Self-checking bench for sreg_tx_param. It instantiates an 8-bit DUT and a
// 512-bit DUT. The 8-bit DUT is compared on every cycle against a
// bit-queue model of the transmitted stream. Both DUTs are additionally
// pinned by literal expectations on captured bit streams and timing.
// Honours SREG_TX_PARAM_BACK2BACK_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_sreg_tx_param;

`ifdef SREG_TX_PARAM_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         valid8;
  logic [7:0]   pi8;
  logic         ready8, so8, sv8, last8, done8;
  logic         valid512;
  logic [511:0] pi512;
  logic         ready512, so512, sv512, last512, done512;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  sreg_tx_param #(.SIZE(8)) dut8 (
    .sreg_tx_param_cport_clk   (clk),
    .sreg_tx_param_cport_rst   (rst_n),
    .sreg_tx_param_cport_en    (en),
    .sreg_tx_param_iport_valid (valid8),
    .sreg_tx_param_ipport_pi   (pi8),
    .sreg_tx_param_oport_ready (ready8),
    .sreg_tx_param_oport_so    (so8),
    .sreg_tx_param_oport_sv    (sv8),
    .sreg_tx_param_oport_last  (last8),
    .sreg_tx_param_oport_done  (done8)
  );

  sreg_tx_param #(.SIZE(512)) dut512 (
    .sreg_tx_param_cport_clk   (clk),
    .sreg_tx_param_cport_rst   (rst_n),
    .sreg_tx_param_cport_en    (en),
    .sreg_tx_param_iport_valid (valid512),
    .sreg_tx_param_ipport_pi   (pi512),
    .sreg_tx_param_oport_ready (ready512),
    .sreg_tx_param_oport_so    (so512),
    .sreg_tx_param_oport_sv    (sv512),
    .sreg_tx_param_oport_last  (last512),
    .sreg_tx_param_oport_done  (done512)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Model: the stream of bits still to be presented for the 8-bit DUT.
  // Front of the queue is the bit on so; an empty queue means idle.
  // -------------------------------------------------------------------------
  bit exp_q[$];
  bit exp_done;

  function automatic bit m_ready();
    return en && (exp_q.size() == 0 || (B2B && exp_q.size() == 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else if (en) begin
      bit acc;
      acc = valid8 && m_ready();
      if (exp_q.size() > 0) begin
        exp_done = (exp_q.size() == 1);
        void'(exp_q.pop_front());
      end else begin
        exp_done = 1'b0;
      end
      if (acc)
        for (int i = 7; i >= 0; i--) exp_q.push_back(pi8[i]);
    end
  end

  // -------------------------------------------------------------------------
  // Monitors (sampled on the falling edge)
  // -------------------------------------------------------------------------
  logic [15:0] cap;
  int ncap, ndone, nsv, first_sv, last_sv, last_c, done_c;
  int idx512, ones512, first512, lastidx512, lastc512, donec512, nd512, nsv512;

  task automatic clr_mon();
    cap = '0; ncap = 0; ndone = 0; nsv = 0;
    first_sv = -1; last_sv = -1; last_c = -1; done_c = -1;
  endtask

  always @(negedge clk) begin
    // Per-cycle model comparison for the 8-bit DUT.
    check("ready", ready8, m_ready());
    check("sv",    sv8,    exp_q.size() > 0);
    check("so",    so8,    exp_q.size() > 0 ? exp_q[0] : 1'b0);
    check("last",  last8,  exp_q.size() == 1);
    check("done",  done8,  exp_done);
    if (sv8) begin
      nsv++;
      if (first_sv < 0) first_sv = cyc;
      last_sv = cyc;
    end
    if (en && sv8) begin
      cap = {cap[14:0], so8};
      ncap++;
      if (last8) last_c = cyc;
    end
    if (en && done8) begin
      ndone++;
      if (done_c < 0) done_c = cyc;
    end
    // 512-bit DUT stream monitor.
    if (sv512) nsv512++;
    if (en && sv512) begin
      idx512++;
      if (so512) ones512++;
      if (idx512 == 1) first512 = int'(so512);
      if (last512) begin lastidx512 = idx512; lastc512 = cyc; end
    end
    if (en && done512) begin nd512++; donec512 = cyc; end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted. On return, the accept edge
  // has just passed. acc_cyc is the cycle in which ready was seen high.
  task automatic send(input logic [7:0] d, input bit keep, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    valid8 = 1'b1;
    pi8    = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (ready8) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
    end
    check("send_timeout", ok, 1'b1);
    @(posedge clk);
    #1;
    if (!keep) begin
      valid8 = 1'b0;
      pi8    = 8'h00;
    end
  endtask

  int k;

  initial begin
    rst_n = 1'b0; en = 1'b1; valid8 = 1'b0; pi8 = '0;
    valid512 = 1'b0; pi512 = '0;
    idx512 = 0; ones512 = 0; first512 = -1; lastidx512 = -1;
    lastc512 = -1; donec512 = -1; nd512 = 0; nsv512 = 0;
    clr_mon();

    // Reset state
    run(2);
    check("rst_so",    so8,    1'b0);
    check("rst_sv",    sv8,    1'b0);
    check("rst_last",  last8,  1'b0);
    check("rst_done",  done8,  1'b0);
    check("rst_ready", ready8, 1'b1);
    rst_n = 1'b1;
    run(2);

    // Test 1: A5 basic frame and timing
    clr_mon();
    send(8'hA5, 1'b0, k);
    run(12);
    $display("word A5: bits=%0h n=%0d done=%0d", cap[7:0], ncap, ndone);
    check("a5_bits",      cap[7:0],   8'hA5);
    check("a5_nbits",     ncap,       8);
    check("a5_ndone",     ndone,      1);
    check("a5_last_lat",  last_c - k, 8);
    check("a5_done_lat",  done_c - k, 9);

    // Test 2: 81 with en toggling during SHIFT
    clr_mon();
    send(8'h81, 1'b0, k);
    for (int i = 0; i < 20; i++) begin
      en = (i % 2 == 0) ? 1'b1 : 1'b0;
      run(1);
    end
    en = 1'b1;
    run(6);
    $display("word 81 stalled: bits=%0h n=%0d done=%0d", cap[7:0], ncap, ndone);
    check("stall_bits",  cap[7:0], 8'h81);
    check("stall_nbits", ncap,     8);
    check("stall_ndone", ndone,    1);
    check("stall_nogap", last_sv - first_sv + 1, nsv);

    // Test 3: FF then 00 with valid held
    clr_mon();
    send(8'hFF, 1'b1, k);
    send(8'h00, 1'b0, k);
    run(20);
    $display("words FF,00: bits=%0h span=%0d sv=%0d", cap, last_sv - first_sv + 1, nsv);
    check("b2b_bits",  cap,   16'hFF00);
    check("b2b_nsv",   nsv,   16);
    check("b2b_span",  last_sv - first_sv + 1, B2B ? 16 : 17);
    check("b2b_ndone", ndone, 2);

    // Test 4: reset in the middle of C3
    clr_mon();
    send(8'hC3, 1'b0, k);
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_so",    so8,    1'b0);
    check("arst_sv",    sv8,    1'b0);
    check("arst_last",  last8,  1'b0);
    check("arst_done",  done8,  1'b0);
    check("arst_ready", ready8, 1'b1);
    clr_mon();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(4);
    check("arst_no_done", ndone, 0);
    check("arst_no_sv",   nsv,   0);
    clr_mon();
    send(8'h5A, 1'b0, k);
    run(12);
    $display("word 5A after reset: bits=%0h n=%0d", cap[7:0], ncap);
    check("post_rst_bits", cap[7:0], 8'h5A);
    check("post_rst_done", ndone,    1);

    // Test 5: valid while busy
    clr_mon();
    send(8'hA5, 1'b0, k);
    run(2);
    valid8 = 1'b1;
    pi8    = 8'h3C;
    @(negedge clk);
    check("busy_ready", ready8, 1'b0);
    send(8'h3C, 1'b0, k);
    run(12);
    $display("words A5,3C busy: bits=%0h done=%0d", cap, ndone);
    check("busy_bits",  cap,   16'hA53C);
    check("busy_ndone", ndone, 2);

    // Test 6: 512-bit walking one
    pi512 = '0;
    pi512[511] = 1'b1;
    valid512 = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        if (ready512) ok = 1'b1;
      end
      check("w512_timeout", ok, 1'b1);
    end
    @(posedge clk);
    #1;
    valid512 = 1'b0;
    pi512 = '0;
    run(520);
    $display("word 512 walking one: ones=%0d last_at=%0d done=%0d", ones512, lastidx512, nd512);
    check("w512_first", first512,   1);
    check("w512_ones",  ones512,    1);
    check("w512_last",  lastidx512, 512);
    check("w512_done",  donec512 - lastc512, 1);
    check("w512_nd",    nd512,      1);
    check("w512_nsv",   nsv512,     512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
